// File: rtl/tc_pkg.sv
// Shared definitions for the tc_timer block: register offsets, CTRL layout,
// FSM encoding and the bus request bundle.
package tc_pkg;

  localparam logic [1:0] TC_CTRL     = 2'd0;
  localparam logic [1:0] TC_PRESET   = 2'd1;
  localparam logic [1:0] TC_COUNT    = 2'd2;
  localparam logic [1:0] TC_PRESCALE = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  // Field order matches CTRL bit positions: im=3, mode=2:1, en=0.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } tc_req_t;

  // Modes 2 and 3 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/tc_prescaler.sv
// Free-running prescale counter; tick fires when the counter reaches limit,
// then the counter restarts from 0. Used only when TC_PRESCALE_EN is defined.
module tc_prescaler
  #(parameter int PRE_W = 8)
  (input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [PRE_W-1:0] limit,
   output logic             tick);

  logic [PRE_W-1:0] cnt;

  // >= keeps the divider from running the full range if limit is lowered mid-count.
  assign tick = en && (cnt >= limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + PRE_W'(1);
  end

endmodule

// File: rtl/tc_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Optional prescaler enabled with TC_PRESCALE_EN.
module tc_timer
  import tc_pkg::*;
  #(parameter int CNT_W = 32,
    parameter int PRE_W = 8)
  (input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  sel,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq);

  tc_req_t          req;
  tc_ctrl_t         ctrl;
  tc_state_e        state;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             irq_pend;
  logic             tick;
  logic             wr_ctrl;
  logic             wr_preset;
  logic             expire;
  logic             pend_clr;

  assign req       = '{sel: sel, we: we, byteen: byteen, wdata: wdata};
  assign wr_ctrl   = req.we && (req.sel == TC_CTRL);
  assign wr_preset = req.we && (req.sel == TC_PRESET);

  // Terminal step of the count: a tick in CNT with COUNT at 1 or 0.
  assign expire   = (state == CNT) && ctrl.en && tick && (count_q <= CNT_W'(1));
  assign pend_clr = wr_ctrl || ((state == INT) && is_reload(ctrl.mode));

`ifdef TC_PRESCALE_EN
  logic [PRE_W-1:0] prescale_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prescale_q <= '0;
    else if (req.we && (req.sel == TC_PRESCALE))
      for (int i = 0; i < PRE_W; i++)
        if (req.byteen[i/8]) prescale_q[i] <= req.wdata[i];
  end

  tc_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == IDLE) || (state == LOAD)),
    .en    (state == CNT),
    .limit (prescale_q),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_preset)
        for (int i = 0; i < CNT_W; i++)
          if (req.byteen[i/8]) preset_q[i] <= req.wdata[i];

      case (state)
        IDLE: if (ctrl.en) state <= LOAD;
        LOAD: begin
          count_q <= preset_q;
          state   <= CNT;
        end
        CNT: begin
          if (!ctrl.en)                  state   <= IDLE;
          else if (tick) begin
            if (count_q > CNT_W'(1))     count_q <= count_q - CNT_W'(1);
            else begin
              count_q <= '0;
              state   <= INT;
            end
          end
        end
        INT: begin
          if (is_reload(ctrl.mode)) state <= LOAD;
          else begin
            ctrl.en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // CPU write is placed after the FSM so it overrides the hardware EN clear.
      if (wr_ctrl && req.byteen[0]) ctrl <= tc_ctrl_t'(req.wdata[3:0]);

      // A new expiry is never lost to a simultaneous clear.
      if (expire)        irq_pend <= 1'b1;
      else if (pend_clr) irq_pend <= 1'b0;
    end
  end

  assign irq = irq_pend & ctrl.im;

  always_comb begin
    rdata = '0;
    case (req.sel)
      TC_CTRL:     rdata[3:0]       = ctrl;
      TC_PRESET:   rdata[CNT_W-1:0] = preset_q;
      TC_COUNT:    rdata[CNT_W-1:0] = count_q;
`ifdef TC_PRESCALE_EN
      TC_PRESCALE: rdata[PRE_W-1:0] = prescale_q;
`endif
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tc_timer.sv
// Directed and randomized checks of tc_timer against an arithmetic timing model.
module tb_tc_timer;
  import tc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int nerr = 0;
  int nchk = 0;

  tc_timer #(.CNT_W(32), .PRE_W(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [3:0] be, input logic [31:0] d);
    sel = s; byteen = be; wdata = d; we = 1'b1;
    step();
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; #2; reset = 1'b1;
    step();
  endtask

  // Reference model: edge k counts from the CTRL write edge (k=0).
  // LOAD happens on edge 2, then one decrement per edge, expiry after max(N,1) steps.
  function automatic int eff(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int m_count(input int k, input int n, input bit au);
    int t;
    if (k < 2) return 0;
    if (!au) begin
      t = k - 2;
      return (n > t) ? n - t : 0;
    end
    t = (k - 2) % (eff(n) + 2);
    return (t <= eff(n) && n > t) ? n - t : 0;
  endfunction

  function automatic bit m_irq(input int k, input int n, input bit au, input bit im);
    if (!im || k < 2) return 1'b0;
    if (au) return ((k - 2) % (eff(n) + 2)) == eff(n);
    return k >= eff(n) + 2;
  endfunction

  task automatic run_check(input string tag, input int n, input bit au, input bit im, input int edges);
    sel = TC_COUNT;
    for (int k = 1; k <= edges; k++) begin
      step();
      chk($sformatf("%s_cnt_e%0d", tag, k), rdata, 32'(m_count(k, n, au)));
      chk($sformatf("%s_irq_e%0d", tag, k), 32'(irq), 32'(m_irq(k, n, au, im)));
    end
  endtask

  initial begin
    int n;
    logic [1:0] md;
    logic im;

    // Reset state
    #2;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      chk($sformatf("rst_reg%0d", s), rdata, 32'd0);
    end
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk); reset = 1'b1;
    step();

    // One-shot
    wr(TC_PRESET, 4'hF, 32'd5);
    wr(TC_CTRL, 4'hF, 32'h9);
    run_check("os", 5, 1'b0, 1'b1, 10);
    sel = TC_CTRL; #1;
    chk("os_ctrl_en_clr", rdata, 32'h8);
    wr(TC_CTRL, 4'hF, 32'h0);
    chk("os_irq_drop", 32'(irq), 32'd0);

    // Auto-reload, 4 periods
    do_reset();
    wr(TC_PRESET, 4'hF, 32'd3);
    wr(TC_CTRL, 4'hF, 32'hB);
    run_check("ar", 3, 1'b1, 1'b1, 20);

    // Masking
    do_reset();
    wr(TC_PRESET, 4'hF, 32'd2);
    wr(TC_CTRL, 4'hF, 32'h1);
    run_check("mk", 2, 1'b0, 1'b0, 6);
    sel = TC_CTRL; #1;
    chk("mk_ctrl", rdata, 32'h0);
    wr(TC_CTRL, 4'hF, 32'h8);
    chk("mk_irq_after_im", 32'(irq), 32'd0);
    sel = TC_CTRL; #1;
    chk("mk_ctrl_im", rdata, 32'h8);

    // Byte lanes and read-only / absent registers
    do_reset();
    wr(TC_PRESET, 4'hF, 32'hAABBCCDD);
    wr(TC_PRESET, 4'b0010, 32'h00001100);
    sel = TC_PRESET; #1;
    chk("bl_preset", rdata, 32'hAABB11DD);
    wr(TC_COUNT, 4'hF, 32'hFFFFFFFF);
    sel = TC_COUNT; #1;
    chk("bl_count_ro", rdata, 32'd0);
    wr(TC_CTRL, 4'b1110, 32'hFFFFFFF0);
    sel = TC_CTRL; #1;
    chk("bl_ctrl_lane0", rdata, 32'h0);
    wr(TC_PRESCALE, 4'hF, 32'hFFFFFFFF);
    sel = TC_PRESCALE; #1;
`ifdef TC_PRESCALE_EN
    chk("bl_prescale", rdata, 32'hFF);
    wr(TC_PRESCALE, 4'hF, 32'h0);
`else
    chk("bl_prescale_absent", rdata, 32'h0);
`endif

    // Pause / resume / async reset
    do_reset();
    wr(TC_PRESET, 4'hF, 32'd100);
    wr(TC_CTRL, 4'hF, 32'h1);
    run_check("pz", 100, 1'b0, 1'b0, 41);
    wr(TC_CTRL, 4'hF, 32'h0);
    sel = TC_COUNT; #1;
    chk("pz_at60", rdata, 32'd60);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pz_hold%0d", i), rdata, 32'd60);
    end
    wr(TC_CTRL, 4'hF, 32'h1);
    sel = TC_COUNT;
    step();
    step();
    chk("pz_reload", rdata, 32'd100);
    step();
    chk("pz_dec", rdata, 32'd99);
    #2; reset = 1'b0; #1;
    chk("pz_async_cnt", rdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    step();
    wr(TC_PRESET, 4'hF, 32'd1);
    wr(TC_CTRL, 4'hF, 32'h9);
    step(); step(); step();
    chk("ar_irq_before_rst", 32'(irq), 32'd1);
    #2; reset = 1'b0; #1;
    chk("rst_async_irq", 32'(irq), 32'd0);
    sel = TC_CTRL; #1;
    chk("rst_async_ctrl", rdata, 32'd0);
    sel = TC_PRESET; #1;
    chk("rst_async_preset", rdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    step();

    // PRESET=0 behaves as 1
    wr(TC_PRESET, 4'hF, 32'd0);
    wr(TC_CTRL, 4'hF, 32'h9);
    run_check("p0", 0, 1'b0, 1'b1, 5);

    // CPU CTRL write on the INT edge keeps EN
    do_reset();
    wr(TC_PRESET, 4'hF, 32'd2);
    wr(TC_CTRL, 4'hF, 32'h9);
    step(); step(); step(); step();
    chk("col_irq_set", 32'(irq), 32'd1);
    wr(TC_CTRL, 4'hF, 32'h9);
    sel = TC_CTRL; #1;
    chk("col_en_kept", rdata, 32'h9);
    chk("col_pend_clr", 32'(irq), 32'd0);
    sel = TC_COUNT;
    step(); step();
    chk("col_restart", rdata, 32'd2);

`ifdef TC_PRESCALE_EN
    // Prescaler: each count step takes PRESCALE+1 cycles
    do_reset();
    wr(TC_PRESCALE, 4'hF, 32'd3);
    wr(TC_PRESET, 4'hF, 32'd2);
    wr(TC_CTRL, 4'hF, 32'h9);
    sel = TC_COUNT;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k >= 2) chk($sformatf("ps_cnt_e%0d", k), rdata, (k < 6) ? 32'd2 : (k < 10) ? 32'd1 : 32'd0);
      chk($sformatf("ps_irq_e%0d", k), 32'(irq), (k >= 10) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized configurations
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n  = int'($urandom_range(0, 12));
      md = 2'($urandom_range(0, 3));
      im = 1'($urandom_range(0, 1));
      wr(TC_PRESET, 4'hF, 32'(n));
      wr(TC_CTRL, 4'hF, {28'd0, im, md, 1'b1});
      run_check($sformatf("rnd%0d_n%0d_m%0d_i%0d", it, n, md, im), n, md == 2'd1, im, 3 * (eff(n) + 2) + 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
